bf16_div_iter: RTL and testbench

BF16_DIV_ITER -- requirements
Module: bf16_div_iter

---
 rtl/bf16_pkg.sv | 55 +++++
 rtl/bf16_div_iter_if.sv | 29 ++
 rtl/bf16_round.sv | 26 ++
 rtl/bf16_div_iter.sv | 236 +++++++++++++++++++++++
 tb/tb_bf16_div_iter.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/bf16_pkg.sv
// Shared widths, constants and types for the iterative bfloat16 divider.
package bf16_pkg;

  localparam int unsigned WIDTH     = 16;
  localparam int unsigned EXP_BITS  = 8;
  localparam int unsigned MAN_BITS  = 7;
  localparam int unsigned BIAS      = 127;
  localparam int unsigned DIV_ITERS = 11;
  localparam int unsigned MODEW     = 3;
  localparam int unsigned SIGW      = MAN_BITS + 1;
  localparam int unsigned SUMW      = SIGW + 1;
  localparam int unsigned REMW      = SIGW + 2;
  localparam int unsigned QW        = DIV_ITERS;
  localparam int unsigned EXPW      = 10;
  localparam int unsigned CNTW      = 4;

  localparam logic [WIDTH-1:0] QNAN       = 16'h7FC0;
  localparam logic [WIDTH-1:0] MAX_FINITE = 16'h7F7F;
  localparam logic [WIDTH-1:0] INF        = 16'h7F80;

  typedef enum logic [MODEW-1:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4
  } rnd_mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    ROUND  = 2'd2,
    DONE   = 2'd3
  } state_e;

  typedef struct packed {
    logic invalid;
    logic div_by_zero;
    logic overflow;
    logic underflow;
    logic inexact;
  } flags_t;

  // Map the raw mode field onto the enum; unused encodings fall back to RNE.
  function automatic rnd_mode_e decode_mode(input logic [MODEW-1:0] m);
    case (m)
      3'd1:    return RTZ;
      3'd2:    return RDN;
      3'd3:    return RUP;
      3'd4:    return RMM;
      default: return RNE;
    endcase
  endfunction

endpackage

// File: rtl/bf16_div_iter_if.sv
// Operand/result handshake bundle for bf16_div_iter.
interface bf16_div_iter_if;
  import bf16_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  operand_a;
  logic [WIDTH-1:0]  operand_b;
  logic [MODEW-1:0]  rnd_mode;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  result;
  logic              invalid;
  logic              div_by_zero;
  logic              overflow;
  logic              underflow;
  logic              inexact;

  modport master (
    output in_valid, operand_a, operand_b, rnd_mode, out_ready,
    input  in_ready, out_valid, result, invalid, div_by_zero, overflow, underflow, inexact
  );

  modport slave (
    input  in_valid, operand_a, operand_b, rnd_mode, out_ready,
    output in_ready, out_valid, result, invalid, div_by_zero, overflow, underflow, inexact
  );

endinterface

// File: rtl/bf16_round.sv
// Rounding increment decision from guard/sticky/lsb/sign and rounding mode.
module bf16_round
  import bf16_pkg::*;
(
  input  logic      sign,
  input  logic      lsb,
  input  logic      guard,
  input  logic      sticky,
  input  rnd_mode_e mode,
  output logic      increment
);

  // Per-mode increment rule.
  always_comb begin
    increment = 1'b0;
    case (mode)
      RNE:     increment = guard & (sticky | lsb);
      RTZ:     increment = 1'b0;
      RDN:     increment = (guard | sticky) & sign;
      RUP:     increment = (guard | sticky) & ~sign;
      RMM:     increment = guard;
      default: increment = guard & (sticky | lsb);
    endcase
  end

endmodule

// File: rtl/bf16_div_iter.sv
// Iterative bfloat16 divider: restoring division, one quotient bit per cycle.
// Optional feature macro: BF16_DIV_RNDMODE_EN (honour rnd_mode; otherwise RNE only).
module bf16_div_iter
  import bf16_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  bf16_div_iter_if.slave bus
);

  localparam logic signed [EXPW-1:0] EXP_OVF  = EXPW'(2**EXP_BITS - 1);
  localparam logic signed [EXPW-1:0] EXP_ZERO = '0;

  state_e                 state_q, state_d;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic [REMW-1:0]        rem_q, rem_d;
  logic [SIGW-1:0]        div_q, div_d;
  logic [QW-1:0]          quo_q, quo_d;
  logic signed [EXPW-1:0] exp_q, exp_d;
  logic                   sign_q, sign_d;
  rnd_mode_e              mode_q, mode_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic [WIDTH-1:0]       result_q, result_d;
  flags_t                 flags_q, flags_d;

  logic                   sign_a, sign_b, sign_in;
  logic [EXP_BITS-1:0]    exp_a, exp_b;
  logic [MAN_BITS-1:0]    man_a, man_b;
  logic                   a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic                   is_special;
  logic [WIDTH-1:0]       spec_res;
  flags_t                 spec_flags;
  rnd_mode_e              mode_in;

  logic                   rem_ge;
  logic [REMW-1:0]        rem_sel;

  logic [SIGW-1:0]        sig;
  logic                   guard, sticky, rnd_inc, ovf_inf;
  logic [SUMW-1:0]        sig_sum;
  logic [MAN_BITS-1:0]    man_r;
  logic signed [EXPW-1:0] exp_n, exp_f;
  logic [WIDTH-1:0]       round_res;
  flags_t                 round_flags;

`ifdef BF16_DIV_RNDMODE_EN
  assign mode_in = decode_mode(bus.rnd_mode);
`else
  assign mode_in = RNE;
  logic unused_rnd_mode;
  assign unused_rnd_mode = ^bus.rnd_mode;
`endif

  // Classify incoming operands and form the special-case answer.
  always_comb begin
    sign_a  = bus.operand_a[WIDTH-1];
    sign_b  = bus.operand_b[WIDTH-1];
    exp_a   = bus.operand_a[WIDTH-2 -: EXP_BITS];
    exp_b   = bus.operand_b[WIDTH-2 -: EXP_BITS];
    man_a   = bus.operand_a[MAN_BITS-1:0];
    man_b   = bus.operand_b[MAN_BITS-1:0];
    sign_in = sign_a ^ sign_b;
    a_zero  = (exp_a == '0);
    b_zero  = (exp_b == '0);
    a_inf   = (exp_a == '1) && (man_a == '0);
    b_inf   = (exp_b == '1) && (man_b == '0);
    a_nan   = (exp_a == '1) && (man_a != '0);
    b_nan   = (exp_b == '1) && (man_b != '0);
    is_special = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;
    spec_flags = '0;
    if (a_nan || b_nan) begin
      spec_res           = QNAN;
      spec_flags.invalid = (a_nan & ~man_a[MAN_BITS-1]) | (b_nan & ~man_b[MAN_BITS-1]);
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res           = QNAN;
      spec_flags.invalid = 1'b1;
    end else if (a_inf) begin
      spec_res = {sign_in, INF[WIDTH-2:0]};
    end else if (b_zero) begin
      spec_res               = {sign_in, INF[WIDTH-2:0]};
      spec_flags.div_by_zero = 1'b1;
    end else begin
      spec_res = {sign_in, {(WIDTH-1){1'b0}}};
    end
  end

  // One restoring-division trial subtraction.
  always_comb begin
    rem_ge  = rem_q >= REMW'(div_q);
    rem_sel = rem_ge ? (rem_q - REMW'(div_q)) : rem_q;
  end

  // Normalize the quotient, apply rounding, and detect overflow/underflow.
  always_comb begin
    if (quo_q[QW-1]) begin
      sig    = quo_q[QW-1 -: SIGW];
      guard  = quo_q[QW-1-SIGW];
      sticky = (|quo_q[QW-2-SIGW:0]) | (rem_q != '0);
      exp_n  = exp_q;
    end else begin
      sig    = quo_q[QW-2 -: SIGW];
      guard  = quo_q[QW-2-SIGW];
      sticky = (|quo_q[QW-3-SIGW:0]) | (rem_q != '0);
      exp_n  = exp_q - EXPW'(1);
    end
    sig_sum = {1'b0, sig} + SUMW'(rnd_inc);
    man_r   = sig_sum[SIGW] ? sig_sum[SIGW-1:1] : sig_sum[MAN_BITS-1:0];
    exp_f   = exp_n + EXPW'(sig_sum[SIGW]);
    case (mode_q)
      RNE, RMM: ovf_inf = 1'b1;
      RUP:      ovf_inf = ~sign_q;
      RDN:      ovf_inf = sign_q;
      default:  ovf_inf = 1'b0;
    endcase
    round_flags = '0;
    if (exp_f >= EXP_OVF) begin
      round_res            = ovf_inf ? {sign_q, INF[WIDTH-2:0]}
                                     : (MAX_FINITE | {sign_q, {(WIDTH-1){1'b0}}});
      round_flags.overflow = 1'b1;
      round_flags.inexact  = 1'b1;
    end else if (exp_f <= EXP_ZERO) begin
      round_res             = {sign_q, {(WIDTH-1){1'b0}}};
      round_flags.underflow = 1'b1;
      round_flags.inexact   = 1'b1;
    end else begin
      round_res           = {sign_q, exp_f[EXP_BITS-1:0], man_r};
      round_flags.inexact = guard | sticky;
    end
  end

  bf16_round u_round (
    .sign      (sign_q),
    .lsb       (sig[0]),
    .guard     (guard),
    .sticky    (sticky),
    .mode      (mode_q),
    .increment (rnd_inc)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    div_d    = div_q;
    quo_d    = quo_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    mode_d   = mode_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          sign_d = sign_in;
          mode_d = mode_in;
          if (is_special) begin
            state_d  = DONE;
            result_d = spec_res;
            flags_d  = spec_flags;
          end else begin
            state_d = DIVIDE;
            cnt_d   = '0;
            rem_d   = REMW'({1'b1, man_a});
            div_d   = {1'b1, man_b};
            quo_d   = '0;
            exp_d   = EXPW'(exp_a) - EXPW'(exp_b) + EXPW'(BIAS);
          end
        end
      end
      DIVIDE: begin
        quo_d = {quo_q[QW-2:0], rem_ge};
        rem_d = {rem_sel[REMW-2:0], 1'b0};
        cnt_d = cnt_q + CNTW'(1);
        if (cnt_q == CNTW'(DIV_ITERS - 1)) begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        state_d  = DONE;
        result_d = round_res;
        flags_d  = round_flags;
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      div_q       <= '0;
      quo_q       <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      mode_q      <= RNE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      div_q       <= div_d;
      quo_q       <= quo_d;
      exp_q       <= exp_d;
      sign_q      <= sign_d;
      mode_q      <= mode_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.result      = result_q;
  assign bus.invalid     = flags_q.invalid;
  assign bus.div_by_zero = flags_q.div_by_zero;
  assign bus.overflow    = flags_q.overflow;
  assign bus.underflow   = flags_q.underflow;
  assign bus.inexact     = flags_q.inexact;

endmodule

// File: tb/tb_bf16_div_iter.sv
// Directed vector bench for bf16_div_iter; flags packed as {NV,DZ,OF,UF,NX}.
module tb_bf16_div_iter;

`ifdef BF16_DIV_RNDMODE_EN
  localparam bit MODES = 1'b1;
`else
  localparam bit MODES = 1'b0;
`endif

  localparam logic [4:0] F_0  = 5'b00000;
  localparam logic [4:0] F_NV = 5'b10000;
  localparam logic [4:0] F_DZ = 5'b01000;
  localparam logic [4:0] F_OF = 5'b00100;
  localparam logic [4:0] F_UF = 5'b00010;
  localparam logic [4:0] F_NX = 5'b00001;
  localparam int NV = 31;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  mode;
    logic [15:0] res;
    logic [4:0]  flg;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_fail = 0;
  vec_t vecs[NV];

  bf16_div_iter_if bus ();

  bf16_div_iter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  function automatic logic [4:0] flags_now();
    return {bus.invalid, bus.div_by_zero, bus.overflow, bus.underflow, bus.inexact};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Accept one operation, scramble the inputs, and measure/check the result.
  task automatic run_op(input vec_t v, input string nm);
    int n;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.operand_a = v.a;
    bus.operand_b = v.b;
    bus.rnd_mode  = v.mode;
    bus.out_ready = 1'b1;
    @(posedge clk);
    n = 1;
    #1;
    bus.in_valid  = 1'b0;
    bus.operand_a = 16'($urandom);
    bus.operand_b = 16'($urandom);
    bus.rnd_mode  = 3'($urandom);
    while (!bus.out_valid && n < 40) begin
      @(posedge clk);
      n++;
      #1;
    end
    chk({nm, " latency"}, 32'(n), 32'(v.lat));
    chk({nm, " result"}, 32'(bus.result), 32'(v.res));
    chk({nm, " flags"}, 32'(flags_now()), 32'(v.flg));
    chk({nm, " in_ready"}, 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    vec_t v;
    vecs[0]  = '{16'h3F80, 16'h4000, 3'd0, 16'h3F00, F_0, 13};
    vecs[1]  = '{16'h3F80, 16'h4040, 3'd0, 16'h3EAB, F_NX, 13};
    vecs[2]  = '{16'h3F80, 16'h4040, 3'd1, MODES ? 16'h3EAA : 16'h3EAB, F_NX, 13};
    vecs[3]  = '{16'h3F80, 16'h4040, 3'd3, 16'h3EAB, F_NX, 13};
    vecs[4]  = '{16'h3F80, 16'h4040, 3'd2, MODES ? 16'h3EAA : 16'h3EAB, F_NX, 13};
    vecs[5]  = '{16'hBF80, 16'h4040, 3'd2, 16'hBEAB, F_NX, 13};
    vecs[6]  = '{16'h3F80, 16'h4040, 3'd7, 16'h3EAB, F_NX, 13};
    vecs[7]  = '{16'h3F80, 16'h0000, 3'd0, 16'h7F80, F_DZ, 1};
    vecs[8]  = '{16'h0000, 16'h0000, 3'd0, 16'h7FC0, F_NV, 1};
    vecs[9]  = '{16'h7F00, 16'h0080, 3'd0, 16'h7F80, F_OF | F_NX, 13};
    vecs[10] = '{16'h7F00, 16'h0080, 3'd1, MODES ? 16'h7F7F : 16'h7F80, F_OF | F_NX, 13};
    vecs[11] = '{16'hFF00, 16'h0080, 3'd3, MODES ? 16'hFF7F : 16'hFF80, F_OF | F_NX, 13};
    vecs[12] = '{16'h7F00, 16'h0080, 3'd4, 16'h7F80, F_OF | F_NX, 13};
    vecs[13] = '{16'hBF80, 16'h4000, 3'd0, 16'hBF00, F_0, 13};
    vecs[14] = '{16'h4040, 16'h4000, 3'd0, 16'h3FC0, F_0, 13};
    vecs[15] = '{16'h3F80, 16'h3F81, 3'd0, 16'h3F7E, F_NX, 13};
    vecs[16] = '{16'h3F80, 16'h3F81, 3'd3, MODES ? 16'h3F7F : 16'h3F7E, F_NX, 13};
    vecs[17] = '{16'h0080, 16'h4000, 3'd0, 16'h0000, F_UF | F_NX, 13};
    vecs[18] = '{16'h8080, 16'h4000, 3'd0, 16'h8000, F_UF | F_NX, 13};
    vecs[19] = '{16'h7FC0, 16'h3F80, 3'd0, 16'h7FC0, F_0, 1};
    vecs[20] = '{16'h7F81, 16'h3F80, 3'd0, 16'h7FC0, F_NV, 1};
    vecs[21] = '{16'h3F80, 16'hFF81, 3'd0, 16'h7FC0, F_NV, 1};
    vecs[22] = '{16'h7F80, 16'h7F80, 3'd0, 16'h7FC0, F_NV, 1};
    vecs[23] = '{16'h7F80, 16'hBF80, 3'd0, 16'hFF80, F_0, 1};
    vecs[24] = '{16'h3F80, 16'h7F80, 3'd0, 16'h0000, F_0, 1};
    vecs[25] = '{16'h8000, 16'h3F80, 3'd0, 16'h8000, F_0, 1};
    vecs[26] = '{16'h0001, 16'h3F80, 3'd0, 16'h0000, F_0, 1};
    vecs[27] = '{16'h3F80, 16'h0001, 3'd0, 16'h7F80, F_DZ, 1};
    vecs[28] = '{16'h7F80, 16'h0000, 3'd0, 16'h7F80, F_0, 1};
    vecs[29] = '{16'h3FFE, 16'h3FFF, 3'd0, 16'h3F7F, F_NX, 13};
    vecs[30] = '{16'hBF80, 16'h8000, 3'd0, 16'h7F80, F_DZ, 1};

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.rnd_mode  = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset result", 32'(bus.result), 32'h0);
    chk("reset flags", 32'(flags_now()), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i], $sformatf("v%0d", i));
    end

    // Backpressure: result must hold while out_ready stays low; busy-time inputs ignored.
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.operand_a = 16'h4040;
    bus.operand_b = 16'h4040;
    bus.rnd_mode  = 3'd0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    n = 1;
    #1;
    bus.operand_a = 16'h3F80;
    bus.operand_b = 16'h0000;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk);
      n++;
      #1;
    end
    chk("hold latency", 32'(n), 32'd13);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("hold%0d result", k), 32'(bus.result), 32'h3F80);
      chk($sformatf("hold%0d flags", k), 32'(flags_now()), 32'h0);
      chk($sformatf("hold%0d in_ready", k), 32'(bus.in_ready), 32'd0);
      chk($sformatf("hold%0d out_valid", k), 32'(bus.out_valid), 32'd1);
      if (k == 4) bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    chk("hold6 out_valid", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("xfer out_valid", 32'(bus.out_valid), 32'd0);
    chk("xfer in_ready", 32'(bus.in_ready), 32'd1);

    // Asynchronous reset mid-division discards the operation.
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.operand_a = 16'h3F80;
    bus.operand_b = 16'h4040;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst result", 32'(bus.result), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) break;
    end
    chk("post-rst idle out_valid", 32'(bus.out_valid), 32'd0);
    chk("post-rst idle in_ready", 32'(bus.in_ready), 32'd1);
    v = '{16'h4000, 16'h4000, 3'd0, 16'h3F80, F_0, 13};
    run_op(v, "post-rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
